// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Definitions shared by the SSM2603 audio path (ADC receiver and DAC
// serializer): default word/slot sizes, the receiver state encoding and
// the channel encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int AUDIO_SAMPLE_BITS = 16;
    localparam int I2S_SLOT_BITS     = 32;

    typedef enum logic [1:0] {
        ALIGN   = 2'd0,
        CAPTURE = 2'd1,
        PAD     = 2'd2
    } rx_state_e;

    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

    // LRCK level to channel: low is left, high is right.
    function automatic logic lr_to_ch(input logic lr);
        return lr ? CH_R : CH_L;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings the asynchronous codec lines into the system clock domain.
// BCLK uses three flops so a rising edge can be detected; LRCK and data use
// two flops each, so all three lines have the same latency and the data/LRCK
// values seen in a bclk_rise cycle were sampled together with that edge.
// Ports:
//   clock       in   system clock
//   reset       in   synchronous active-high reset, clears all flops
//   bclk        in   codec bit clock (async)
//   lrclk       in   codec LR clock (async)
//   dat         in   codec serial data (async)
//   bclk_rise   out  one-cycle pulse per synchronised BCLK rising edge
//   lrclk_sync  out  synchronised LRCK
//   dat_sync    out  synchronised data
// -----------------------------------------------------------------------------
module sync_edge_det
    import audio_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic bclk,
    input  logic lrclk,
    input  logic dat,
    output logic bclk_rise,
    output logic lrclk_sync,
    output logic dat_sync
);

    logic [2:0] bclk_sync_r;
    logic [1:0] lrclk_sync_r;
    logic [1:0] dat_sync_r;

    // Synchroniser shift chains; index 0 is the first (metastable) stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            bclk_sync_r  <= 3'b000;
            lrclk_sync_r <= 2'b00;
            dat_sync_r   <= 2'b00;
        end else begin
            bclk_sync_r  <= {bclk_sync_r[1:0], bclk};
            lrclk_sync_r <= {lrclk_sync_r[0], lrclk};
            dat_sync_r   <= {dat_sync_r[0], dat};
        end
    end

    assign bclk_rise  = bclk_sync_r[1] & ~bclk_sync_r[2];
    assign lrclk_sync = lrclk_sync_r[1];
    assign dat_sync   = dat_sync_r[1];

endmodule

// File: rtl/ssm2603_adc_rx.sv
// -----------------------------------------------------------------------------
// ssm2603_adc_rx
// I2S receive deserializer for the SSM2603 ADC path. Oversamples BCLK,
// ADCLRCK and ADCDAT, captures the first SAMPLE_BITS bits of each slot
// (MSB first, one-bit I2S delay) and offers left/right pairs through a
// valid/ready handshake. Capture always starts on a left slot.
// Ports:
//   clock         in   18.432 MHz system clock
//   reset         in   synchronous active-high reset
//   aud_bclk      in   codec bit clock (async, nominally clock/9)
//   aud_adclrck   in   codec LR clock (async), low = left
//   aud_adcdat    in   codec serial data (async)
//   sample_l      out  left sample, two's complement
//   sample_r      out  right sample, two's complement
//   sample_valid  out  a sample pair is available
//   sample_ready  in   consumer accepts the pair
//   overrun       out  sticky: a completed pair was dropped
//   frame_error   out  sticky: a slot ended before SAMPLE_BITS bits
//   clear_errors  in   pulse clearing both sticky bits
// -----------------------------------------------------------------------------
module ssm2603_adc_rx
    import audio_pkg::*;
#(
    parameter int SAMPLE_BITS = AUDIO_SAMPLE_BITS,
    parameter int SLOT_BITS   = I2S_SLOT_BITS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   aud_bclk,
    input  logic                   aud_adclrck,
    input  logic                   aud_adcdat,
    output logic [SAMPLE_BITS-1:0] sample_l,
    output logic [SAMPLE_BITS-1:0] sample_r,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic                   overrun,
    output logic                   frame_error,
    input  logic                   clear_errors
);

    // Counter is wide enough to hold a full nominal slot.
    localparam int CNT_W = $clog2(SLOT_BITS + 1);

    logic bclk_rise_s;
    logic lr_s;
    logic dat_s;

    rx_state_e              state_r, state_n;
    logic                   ch_r, ch_n;
    logic [CNT_W-1:0]       bitcnt_r, bitcnt_n;
    logic [SAMPLE_BITS-1:0] shift_r, shift_n;
    logic [SAMPLE_BITS-1:0] hold_l_r, hold_l_n;
    logic                   hold_l_valid_r, hold_l_valid_n;
    logic                   lr_prev_r, lr_prev_n;

    logic [SAMPLE_BITS-1:0] word_s;
    logic                   boundary_s;
    logic                   last_bit_s;
    logic                   pair_done_s;
    logic                   frame_err_set_s;
    logic                   overrun_set_s;

    logic [SAMPLE_BITS-1:0] sample_l_r;
    logic [SAMPLE_BITS-1:0] sample_r_r;
    logic                   valid_r;
    logic                   overrun_r;
    logic                   frame_error_r;

    sync_edge_det u_sync (
        .clock      (clock),
        .reset      (reset),
        .bclk       (aud_bclk),
        .lrclk      (aud_adclrck),
        .dat        (aud_adcdat),
        .bclk_rise  (bclk_rise_s),
        .lrclk_sync (lr_s),
        .dat_sync   (dat_s)
    );

    // Word as it stands after shifting in the current data bit.
    assign word_s     = {shift_r[SAMPLE_BITS-2:0], dat_s};
    assign boundary_s = bclk_rise_s & (lr_s != lr_prev_r);
    assign last_bit_s = (bitcnt_r == CNT_W'(SAMPLE_BITS - 1));

    // Capture state and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ALIGN;
            ch_r           <= CH_L;
            bitcnt_r       <= '0;
            shift_r        <= '0;
            hold_l_r       <= '0;
            hold_l_valid_r <= 1'b0;
            lr_prev_r      <= 1'b1;
        end else begin
            state_r        <= state_n;
            ch_r           <= ch_n;
            bitcnt_r       <= bitcnt_n;
            shift_r        <= shift_n;
            hold_l_r       <= hold_l_n;
            hold_l_valid_r <= hold_l_valid_n;
            lr_prev_r      <= lr_prev_n;
        end
    end

    // Next-state logic; all protocol actions are gated by bclk_rise.
    always_comb begin
        state_n         = state_r;
        ch_n            = ch_r;
        bitcnt_n        = bitcnt_r;
        shift_n         = shift_r;
        hold_l_n        = hold_l_r;
        hold_l_valid_n  = hold_l_valid_r;
        lr_prev_n       = lr_prev_r;
        pair_done_s     = 1'b0;
        frame_err_set_s = 1'b0;
        if (bclk_rise_s) begin
            lr_prev_n = lr_s;
            case (state_r)
                ALIGN: begin
                    if (boundary_s && (lr_to_ch(lr_s) == CH_L)) begin
                        state_n  = CAPTURE;
                        ch_n     = CH_L;
                        bitcnt_n = '0;
                    end else begin
                        state_n = ALIGN;
                    end
                end
                CAPTURE: begin
                    if (boundary_s) begin
                        // Short slot: drop the partial word and any held left
                        // word. A new left slot restarts capture at once; a
                        // right slot would have no partner, so realign.
                        frame_err_set_s = 1'b1;
                        hold_l_valid_n  = 1'b0;
                        bitcnt_n        = '0;
                        ch_n            = CH_L;
                        if (lr_to_ch(lr_s) == CH_L) begin
                            state_n = CAPTURE;
                        end else begin
                            state_n = ALIGN;
                        end
                    end else begin
                        shift_n  = word_s;
                        bitcnt_n = bitcnt_r + CNT_W'(1);
                        if (last_bit_s) begin
                            state_n = PAD;
                            if (ch_r == CH_L) begin
                                hold_l_n       = word_s;
                                hold_l_valid_n = 1'b1;
                            end else begin
                                pair_done_s    = hold_l_valid_r;
                                hold_l_valid_n = 1'b0;
                            end
                        end else begin
                            state_n = CAPTURE;
                        end
                    end
                end
                PAD: begin
                    if (boundary_s) begin
                        bitcnt_n = '0;
                        if ((ch_r == CH_L) && (lr_to_ch(lr_s) == CH_R)) begin
                            state_n = CAPTURE;
                            ch_n    = CH_R;
                        end else if ((ch_r == CH_R) && (lr_to_ch(lr_s) == CH_L)) begin
                            state_n = CAPTURE;
                            ch_n    = CH_L;
                        end else begin
                            state_n        = ALIGN;
                            hold_l_valid_n = 1'b0;
                        end
                    end else begin
                        state_n = PAD;
                    end
                end
                default: begin
                    state_n        = ALIGN;
                    hold_l_valid_n = 1'b0;
                end
            endcase
        end else begin
            lr_prev_n = lr_prev_r;
        end
    end

    assign overrun_set_s = pair_done_s & valid_r & ~sample_ready;

    // Output pair register and valid/ready handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            sample_l_r <= '0;
            sample_r_r <= '0;
            valid_r    <= 1'b0;
        end else if (pair_done_s && (!valid_r || sample_ready)) begin
            sample_l_r <= hold_l_r;
            sample_r_r <= word_s;
            valid_r    <= 1'b1;
        end else if (!pair_done_s && valid_r && sample_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Sticky error bits; a set event beats a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            overrun_r     <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (clear_errors) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
            if (frame_err_set_s) begin
                frame_error_r <= 1'b1;
            end else if (clear_errors) begin
                frame_error_r <= 1'b0;
            end else begin
                frame_error_r <= frame_error_r;
            end
        end
    end

    assign sample_l     = sample_l_r;
    assign sample_r     = sample_r_r;
    assign sample_valid = valid_r;
    assign overrun      = overrun_r;
    assign frame_error  = frame_error_r;

endmodule

// File: tb/tb_ssm2603_adc_rx.sv
// -----------------------------------------------------------------------------
// tb_ssm2603_adc_rx
// Directed bench for ssm2603_adc_rx. An I2S source model drives BCLK at
// clock/9 (4 low / 5 high), changing LRCK and data while BCLK is low. Each
// slot is: one delay bit, 16 data bits MSB first, then padding ones.
// Inputs change 1 time unit after a rising clock edge; outputs are sampled
// at the same point.
// -----------------------------------------------------------------------------
module tb_ssm2603_adc_rx;

    logic        clock;
    logic        reset;
    logic        aud_bclk;
    logic        aud_adclrck;
    logic        aud_adcdat;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic        overrun;
    logic        frame_error;
    logic        clear_errors;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    ssm2603_adc_rx dut (
        .clock        (clock),
        .reset        (reset),
        .aud_bclk     (aud_bclk),
        .aud_adclrck  (aud_adclrck),
        .aud_adcdat   (aud_adcdat),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .frame_error  (frame_error),
        .clear_errors (clear_errors)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One BCLK period: 4 clocks low (data/LRCK change here), 5 clocks high.
    task automatic send_bit(input logic lr, input logic d);
        aud_bclk    = 1'b0;
        aud_adclrck = lr;
        aud_adcdat  = d;
        repeat (4) @(posedge clock);
        #1;
        aud_bclk = 1'b1;
        repeat (5) @(posedge clock);
        #1;
    endtask

    // Delay bit followed by the top n bits of w.
    task automatic send_head(input logic lr, input logic [15:0] w, input int n);
        send_bit(lr, 1'b1);
        for (int i = 15; i > 15 - n; i--) begin
            send_bit(lr, w[i]);
        end
    endtask

    task automatic send_pad(input logic lr, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(lr, 1'b1);
        end
    endtask

    task automatic send_slot(input logic lr, input logic [15:0] w, input int len);
        send_head(lr, w, 16);
        send_pad(lr, len - 17);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, 32);
    endtask

    task automatic pulse_ready();
        sample_ready = 1'b1;
        @(posedge clock);
        #1;
        sample_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        @(posedge clock);
        #1;
        clear_errors = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] w5;
        reset        = 1'b1;
        aud_bclk     = 1'b0;
        aud_adclrck  = 1'b1;
        aud_adcdat   = 1'b0;
        sample_ready = 1'b0;
        clear_errors = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_sample_l", sample_l, 32'h0);
        check("rst_sample_r", sample_r, 32'h0);
        check("rst_valid", sample_valid, 32'h0);
        check("rst_overrun", overrun, 32'h0);
        check("rst_frame_error", frame_error, 32'h0);

        // Test 1: basic pair with ready held high, exact valid timing.
        // E0 is the first clock edge sampling BCLK high on the right LSB;
        // valid must appear on the third edge counting E0 (E0, E1, E2).
        sample_ready = 1'b1;
        send_slot(1'b0, 16'h8001, 32);
        send_head(1'b1, 16'h7FFE, 15);
        aud_bclk    = 1'b0;
        aud_adclrck = 1'b1;
        aud_adcdat  = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        aud_bclk = 1'b1;
        @(posedge clock); #1;
        check("t1_valid_after_e0", sample_valid, 32'h0);
        @(posedge clock); #1;
        check("t1_valid_after_e1", sample_valid, 32'h0);
        @(posedge clock); #1;
        check("t1_valid_after_e2", sample_valid, 32'h1);
        check("t1_sample_l", sample_l, 32'h8001);
        check("t1_sample_r", sample_r, 32'h7FFE);
        @(posedge clock); #1;
        check("t1_valid_pulse_end", sample_valid, 32'h0);
        @(posedge clock); #1;
        send_pad(1'b1, 15);
        sample_ready = 1'b0;

        // Test 2: stream begins mid right slot; partial frame must not appear.
        do_reset();
        send_head(1'b1, 16'hDEAD, 10);
        send_pad(1'b1, 8);
        send_slot(1'b0, 16'h1234, 32);
        check("t2_no_partial_pair", sample_valid, 32'h0);
        send_slot(1'b1, 16'hABCD, 32);
        check("t2_valid", sample_valid, 32'h1);
        check("t2_sample_l", sample_l, 32'h1234);
        check("t2_sample_r", sample_r, 32'hABCD);
        pulse_ready();
        check("t2_ready_clears_valid", sample_valid, 32'h0);

        // Test 3: overrun with ready low over two frames.
        send_frame(16'h1111, 16'h2222);
        check("t3_valid_first", sample_valid, 32'h1);
        check("t3_no_overrun_yet", overrun, 32'h0);
        send_frame(16'h3333, 16'h4444);
        check("t3_hold_l", sample_l, 32'h1111);
        check("t3_hold_r", sample_r, 32'h2222);
        check("t3_valid_held", sample_valid, 32'h1);
        check("t3_overrun", overrun, 32'h1);
        pulse_ready();
        check("t3_valid_cleared", sample_valid, 32'h0);
        send_frame(16'h5A5A, 16'hA5A5);
        check("t3_third_valid", sample_valid, 32'h1);
        check("t3_third_l", sample_l, 32'h5A5A);
        check("t3_third_r", sample_r, 32'hA5A5);
        check("t3_overrun_sticky", overrun, 32'h1);
        pulse_clear();
        check("t3_overrun_cleared", overrun, 32'h0);
        pulse_ready();

        // Test 4: left slot cut short after 10 bits.
        send_head(1'b0, 16'h9999, 10);
        send_slot(1'b1, 16'h7777, 32);
        check("t4_frame_error", frame_error, 32'h1);
        check("t4_no_output", sample_valid, 32'h0);
        send_frame(16'h5555, 16'hAAAA);
        check("t4_valid", sample_valid, 32'h1);
        check("t4_sample_l", sample_l, 32'h5555);
        check("t4_sample_r", sample_r, 32'hAAAA);
        check("t4_frame_error_sticky", frame_error, 32'h1);
        pulse_clear();
        check("t4_frame_error_cleared", frame_error, 32'h0);
        pulse_ready();

        // Test 5: reset in the middle of the right slot; the rest of that
        // right word is still sent afterwards and must not complete a pair.
        w5 = 16'hF0F0;
        send_slot(1'b0, 16'h0F0F, 32);
        send_head(1'b1, w5, 8);
        do_reset();
        check("t5_rst_sample_l", sample_l, 32'h0);
        check("t5_rst_sample_r", sample_r, 32'h0);
        check("t5_rst_valid", sample_valid, 32'h0);
        check("t5_rst_overrun", overrun, 32'h0);
        check("t5_rst_frame_error", frame_error, 32'h0);
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, w5[i]);
        end
        send_pad(1'b1, 15);
        check("t5_no_stale_pair", sample_valid, 32'h0);
        send_frame(16'h1357, 16'h2468);
        check("t5_valid", sample_valid, 32'h1);
        check("t5_sample_l", sample_l, 32'h1357);
        check("t5_sample_r", sample_r, 32'h2468);
        pulse_ready();

        // Test 6: 24-bit slots are not a framing error.
        send_slot(1'b0, 16'hCAFE, 24);
        send_slot(1'b1, 16'hBEEF, 24);
        check("t6_valid", sample_valid, 32'h1);
        check("t6_sample_l", sample_l, 32'hCAFE);
        check("t6_sample_r", sample_r, 32'hBEEF);
        check("t6_no_frame_error", frame_error, 32'h0);
        pulse_ready();
        check("t6_valid_cleared", sample_valid, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
